register_file: RTL and testbench

16-entry × 16-bit register file for the datapath, built from the same storage-register pattern as the single registers. It has one write port, two registered read ports for operand fetch, and a debug dump port. The dump port walks every entry out over a valid/ready handshake. The block sits between the writeback stage, which writes to it, and the ALU operand inputs, which read from it.

---
 rtl/register_file.sv | 124 ++++++++++++
 tb/tb_register_file.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 16x16 storage with two registered read ports
// and a handshaked debug dump walker.
module register_file #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 WriteEnable,
  input  logic [ADDR_BITS-1:0] WriteAddr,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic [ADDR_BITS-1:0] ReadAddrA,
  input  logic [ADDR_BITS-1:0] ReadAddrB,
  output logic [WIDTH-1:0]     ReadDataA,
  output logic [WIDTH-1:0]     ReadDataB,
  input  logic                 DumpStart,
  input  logic                 DumpReady,
  output logic                 DumpValid,
  output logic [ADDR_BITS-1:0] DumpAddr,
  output logic [WIDTH-1:0]     DumpData,
  output logic                 DumpBusy,
  output logic                 DumpDone
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [WIDTH-1:0]     rd_a;
  logic [WIDTH-1:0]     rd_b;
  logic [WIDTH-1:0]     rd_d;
  logic                 load;
  logic [ADDR_BITS-1:0] load_addr;
  logic                 last;

  assign last = (DumpAddr == ADDR_BITS'(DEPTH - 1));

  // Write-first bypass for both operand ports and the dump loader
  always_comb begin
    rd_a = mem[ReadAddrA];
    rd_b = mem[ReadAddrB];
    rd_d = mem[load_addr];
    if (WriteEnable && WriteAddr == ReadAddrA) rd_a = WriteData;
    if (WriteEnable && WriteAddr == ReadAddrB) rd_b = WriteData;
    if (WriteEnable && WriteAddr == load_addr) rd_d = WriteData;
  end

  // Storage array; every entry, including 0, is writable
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (WriteEnable) begin
      mem[WriteAddr] <= WriteData;
    end
  end

  // Registered operand reads
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ReadDataA <= '0;
      ReadDataB <= '0;
    end else begin
      ReadDataA <= rd_a;
      ReadDataB <= rd_b;
    end
  end

  // Dump FSM state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Dump FSM next state and beat-load decision
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_addr = DumpAddr;
    unique case (state)
      IDLE: begin
        if (DumpStart) begin
          state_nxt = SHOW;
          load      = 1'b1;
          load_addr = '0;
        end
      end
      SHOW: begin
        if (DumpReady) begin
          if (last) begin
            state_nxt = DONE;
          end else begin
            load      = 1'b1;
            load_addr = DumpAddr + ADDR_BITS'(1);
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat register; held while stalled and after the last beat
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      DumpAddr <= '0;
      DumpData <= '0;
    end else if (load) begin
      DumpAddr <= load_addr;
      DumpData <= rd_d;
    end
  end

  assign DumpValid = (state == SHOW);
  assign DumpBusy  = (state == SHOW);
  assign DumpDone  = (state == DONE);

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of reads, bypass,
// dump walking, backpressure and reset abort.
module tb_register_file;

  logic        Clock;
  logic        Reset;
  logic        WriteEnable;
  logic [3:0]  WriteAddr;
  logic [15:0] WriteData;
  logic [3:0]  ReadAddrA;
  logic [3:0]  ReadAddrB;
  logic [15:0] ReadDataA;
  logic [15:0] ReadDataB;
  logic        DumpStart;
  logic        DumpReady;
  logic        DumpValid;
  logic [3:0]  DumpAddr;
  logic [15:0] DumpData;
  logic        DumpBusy;
  logic        DumpDone;

  int tests = 0;
  int fails = 0;

  register_file #(.WIDTH(16), .ADDR_BITS(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .WriteEnable(WriteEnable),
    .WriteAddr  (WriteAddr),
    .WriteData  (WriteData),
    .ReadAddrA  (ReadAddrA),
    .ReadAddrB  (ReadAddrB),
    .ReadDataA  (ReadDataA),
    .ReadDataB  (ReadDataB),
    .DumpStart  (DumpStart),
    .DumpReady  (DumpReady),
    .DumpValid  (DumpValid),
    .DumpAddr   (DumpAddr),
    .DumpData   (DumpData),
    .DumpBusy   (DumpBusy),
    .DumpDone   (DumpDone)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    tests++;
    if ({ReadDataA, ReadDataB} !== 32'h0) begin
      fails++;
      $display("FAIL rst_init_rd got %h want 0", {ReadDataA, ReadDataB});
    end
    tests++;
    if ({DumpValid, DumpBusy, DumpDone, DumpAddr, DumpData} !== 23'h0) begin
      fails++;
      $display("FAIL rst_init_dump got v%b b%b d%b a%h d%h want 0",
               DumpValid, DumpBusy, DumpDone, DumpAddr, DumpData);
    end
    WriteEnable = 1; WriteAddr = 3; WriteData = 16'hBEEF;
    step();
    WriteEnable = 0; ReadAddrA = 3; ReadAddrB = 3;
    step();
    tests++;
    if (ReadDataA !== 16'hBEEF) begin
      fails++;
      $display("FAIL rst_pre_rd got %h want beef", ReadDataA);
    end
    #2 Reset = 0;
    #1;
    tests++;
    if ({ReadDataA, ReadDataB} !== 32'h0 || DumpValid !== 1'b0) begin
      fails++;
      $display("FAIL rst_async got a%h b%h v%b want 0",
               ReadDataA, ReadDataB, DumpValid);
    end
    step();
    Reset = 1;
    for (int i = 0; i < 16; i++) begin
      ReadAddrA = 4'(i);
      ReadAddrB = 4'(15 - i);
      step();
      tests++;
      if (ReadDataA !== 16'h0 || ReadDataB !== 16'h0) begin
        fails++;
        $display("FAIL rst_entry%0d got a%h b%h want 0",
                 i, ReadDataA, ReadDataB);
      end
    end
  endtask

  task automatic test_bypass();
    WriteEnable = 1; WriteAddr = 5; WriteData = 16'h1234;
    ReadAddrA = 5; ReadAddrB = 6;
    step();
    WriteEnable = 0;
    tests++;
    if (ReadDataA !== 16'h1234 || ReadDataB !== 16'h0) begin
      fails++;
      $display("FAIL bypass got a%h b%h want a1234 b0000",
               ReadDataA, ReadDataB);
    end
    step();
    tests++;
    if (ReadDataA !== 16'h1234) begin
      fails++;
      $display("FAIL stored_rd got %h want 1234", ReadDataA);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) begin
      WriteEnable = 1; WriteAddr = 4'(i); WriteData = 16'h1000 + 16'(i);
      step();
    end
    WriteEnable = 0;
  endtask

  task automatic test_full_dump();
    preload();
    DumpReady = 1; DumpStart = 1;
    step();
    DumpStart = 0;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (DumpValid !== 1'b1 || DumpBusy !== 1'b1 ||
          DumpAddr !== 4'(i) || DumpData !== 16'h1000 + 16'(i)) begin
        fails++;
        $display("FAIL full_beat%0d got v%b b%b a%h d%h want v1 b1 a%h d%h",
                 i, DumpValid, DumpBusy, DumpAddr, DumpData,
                 4'(i), 16'h1000 + 16'(i));
      end
      step();
    end
    tests++;
    if (DumpDone !== 1'b1 || DumpValid !== 1'b0 || DumpBusy !== 1'b0) begin
      fails++;
      $display("FAIL full_done got d%b v%b b%b want d1 v0 b0",
               DumpDone, DumpValid, DumpBusy);
    end
    step();
    tests++;
    if (DumpDone !== 1'b0 || DumpValid !== 1'b0 ||
        DumpAddr !== 4'hF || DumpData !== 16'h100F) begin
      fails++;
      $display("FAIL full_idle got d%b v%b a%h d%h want d0 v0 af d100f",
               DumpDone, DumpValid, DumpAddr, DumpData);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int xfer;
    int dones;
    int bad;
    pat = 4'b1001;
    xfer = 0; dones = 0; bad = 0;
    DumpReady = 1; DumpStart = 1;
    step();
    DumpStart = 0;
    for (int c = 0; c < 80; c++) begin
      DumpReady = pat[3 - (c % 4)];
      if (DumpValid) begin
        tests++;
        if (xfer > 15 || DumpAddr !== 4'(xfer) ||
            DumpData !== 16'h1000 + 16'(xfer)) begin
          fails++;
          bad++;
          if (bad < 4)
            $display("FAIL bp_beat c%0d got a%h d%h want a%h d%h",
                     c, DumpAddr, DumpData, 4'(xfer), 16'h1000 + 16'(xfer));
        end
        if (DumpReady) xfer++;
      end
      if (DumpDone) dones++;
      step();
    end
    DumpReady = 1;
    tests++;
    if (xfer !== 16 || dones !== 1) begin
      fails++;
      $display("FAIL bp_count got xfer%0d done%0d want xfer16 done1",
               xfer, dones);
    end
  endtask

  task automatic test_write_hold();
    int n;
    DumpReady = 1; DumpStart = 1;
    step();
    DumpStart = 0;
    repeat (7) step();
    DumpReady = 0;
    WriteEnable = 1; WriteAddr = 7; WriteData = 16'hAAAA;
    step();
    WriteEnable = 0;
    tests++;
    if (DumpAddr !== 4'h7 || DumpData !== 16'h1007 || DumpValid !== 1'b1) begin
      fails++;
      $display("FAIL hold_beat7 got v%b a%h d%h want v1 a7 d1007",
               DumpValid, DumpAddr, DumpData);
    end
    step();
    tests++;
    if (DumpAddr !== 4'h7 || DumpData !== 16'h1007) begin
      fails++;
      $display("FAIL hold_beat7b got a%h d%h want a7 d1007",
               DumpAddr, DumpData);
    end
    DumpReady = 1;
    WriteEnable = 1; WriteAddr = 8; WriteData = 16'hBBBB;
    step();
    WriteEnable = 0;
    tests++;
    if (DumpAddr !== 4'h8 || DumpData !== 16'hBBBB) begin
      fails++;
      $display("FAIL load_bypass got a%h d%h want a8 dbbbb",
               DumpAddr, DumpData);
    end
    n = 0;
    while (!DumpDone && n < 40) begin
      step();
      n++;
    end
    tests++;
    if (DumpDone !== 1'b1) begin
      fails++;
      $display("FAIL hold_done got %b want 1 (timeout)", DumpDone);
    end
    ReadAddrA = 7; ReadAddrB = 8;
    step();
    tests++;
    if (ReadDataA !== 16'hAAAA || ReadDataB !== 16'hBBBB) begin
      fails++;
      $display("FAIL hold_rd got a%h b%h want aaaaa bbbbb",
               ReadDataA, ReadDataB);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    DumpReady = 1; DumpStart = 1;
    step();
    DumpStart = 0;
    repeat (9) step();
    tests++;
    if (DumpAddr !== 4'h9 || DumpValid !== 1'b1) begin
      fails++;
      $display("FAIL mid_beat9 got v%b a%h want v1 a9", DumpValid, DumpAddr);
    end
    #2 Reset = 0;
    #1;
    tests++;
    if ({DumpValid, DumpBusy, DumpDone, DumpAddr, DumpData} !== 23'h0) begin
      fails++;
      $display("FAIL mid_abort got v%b b%b d%b a%h d%h want 0",
               DumpValid, DumpBusy, DumpDone, DumpAddr, DumpData);
    end
    step();
    Reset = 1;
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      if (DumpDone || DumpValid) dones++;
      step();
    end
    tests++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL mid_nodone got %0d active cycles want 0", dones);
    end
    DumpStart = 1;
    step();
    DumpStart = 0;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (DumpValid !== 1'b1 || DumpAddr !== 4'(i) || DumpData !== 16'h0) begin
        fails++;
        $display("FAIL redump_beat%0d got v%b a%h d%h want v1 a%h d0000",
                 i, DumpValid, DumpAddr, DumpData, 4'(i));
      end
      step();
    end
    tests++;
    if (DumpDone !== 1'b1) begin
      fails++;
      $display("FAIL redump_done got %b want 1", DumpDone);
    end
  endtask

  initial begin
    Reset = 0;
    WriteEnable = 0; WriteAddr = 0; WriteData = 0;
    ReadAddrA = 0; ReadAddrB = 0;
    DumpStart = 0; DumpReady = 0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1;
    test_reset();
    test_bypass();
    test_full_dump();
    test_backpressure();
    test_write_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
